lq_agen_split_seq: RTL and testbench
====================================

# lq_agen_split_seq

Load/store array-access sequencer that consumes the 12-bit low effective address produced by the agen adder. It splits it into a 64-byte line index (EA 52:57) and byte offset (EA 58:63), and issues one or two registered array accesses per request. A second access is issued only when the access crosses a cache line. It sits between the agen low-order adder and the L1 directory/data array index port, and applies the same bit-57 index override the agen array path uses.

## Interface
Parameters: none (line size fixed at 64 B, index 6 bits, max access 16 B).

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_val  in  1  request valid
- req_rdy  out  1  sequencer can accept a request this cycle
- req_ea  in  [0:11]  EA bits 52:63; [0] is MSB
- req_size  in  [0:2]  000=1B, 001=2B, 010=4B, 011=8B, 100=16B; 101–111 illegal
- req_dir_ig_57_b  in  1  active-low; 0 forces index bit 5 (EA 57) to 1 on every beat
- req_tag  in  [0:3]  opaque tag, returned on each beat
- arr_val  out  1  array access valid
- arr_rdy  in  1  array accepts the beat this cycle
- arr_idx  out  [0:5]  line index
- arr_offs  out  [0:5]  byte offset within line
- arr_len  out  [0:4]  bytes in this beat (1–16)
- arr_tag  out  [0:3]  copy of req_tag
- arr_first  out  1  first beat of a request
- arr_last  out  1  last beat of a request
- arr_pg_wrap  out  1  second beat whose index wrapped 63→0 (4 KB crossing)
- size_err  out  1  one-cycle pulse: an illegal size was accepted
- split_cnt  out  [0:7]  count of split requests, saturates at 255

## Operation
- Request handshake: a request is accepted on an edge with req_val & req_rdy.
- req_rdy = ~arr_val | (arr_rdy & arr_last). This is a combinational path from arr_rdy, so a new request can be accepted on the same edge that retires the last beat of the previous one.
- Beat handshake: a beat retires on an edge with arr_val & arr_rdy.
- While arr_val & ~arr_rdy, every arr_* output holds stable.
- Length decode: L = 1, 2, 4, 8 or 16 from req_size. Illegal sizes decode to L=1 and pulse size_err the cycle after acceptance.
- Split arithmetic:
  - o = req_ea[6:11].
  - e = o + L, computed in 7 bits.
  - split when e > 64.
- Beat 1:
  - arr_idx = req_ea[0:5], with bit 5 forced to 1 if req_dir_ig_57_b=0.
  - arr_offs = o.
  - arr_len = L if there is no split, else 64−o.
  - arr_first=1; arr_last=~split; arr_pg_wrap=0.
- Beat 2 (split only):
  - arr_idx = (req_ea[0:5]+1) mod 64. The increment uses the raw, unmasked index; bit-5 forcing is applied afterward.
  - arr_offs = 0; arr_len = e−64.
  - arr_first=0; arr_last=1.
  - arr_pg_wrap=1 iff req_ea[0:5]=63.
- The tag and the override bit are captured at acceptance and used for both beats.
- split_cnt increments by 1 on acceptance of a split request and does not increment once it reaches 255.
- FSM:
  - IDLE (arr_val=0): on accept → ONE.
  - ONE (beat 1 presented):
    - retire & ~split & no new accept → IDLE;
    - retire & ~split & new accept → ONE, loaded with the new request;
    - retire & split → TWO;
    - otherwise hold.
  - TWO (beat 2 presented):
    - retire & no accept → IDLE;
    - retire & accept → ONE;
    - otherwise hold.
- req_rdy=0 in ONE when the request is split, and in any state while stalled.

## Timing
- Latency: beat 1 is valid the cycle after acceptance.
- Beat 2 is valid the cycle after beat 1 retires.
- Throughput: one beat per cycle with arr_rdy held at 1. Unsplit requests stream back-to-back; a split request costs two cycles.
- Reset (rst=1 at an edge):
  - state IDLE;
  - arr_val, arr_first, arr_last, arr_pg_wrap, size_err = 0;
  - arr_idx, arr_offs, arr_len, arr_tag = 0;
  - split_cnt = 0;
  - req_rdy = 1 from the first cycle after reset.
- Reset mid-operation discards any pending beat 2. No beat retires on the reset edge.
- rst has priority over every other event, including a simultaneous accept.

## Test plan
- Unsplit, arr_rdy=1: ea=0x123, size=010 → next cycle arr_val=1, idx=0x04, offs=0x23, len=4, first=last=1; split_cnt=0.
- Line split: ea=0x03C, size=011 →
  - beat 1: idx=0, offs=60, len=4, first=1, last=0;
  - beat 2: idx=1, offs=0, len=4, last=1, pg_wrap=0;
  - split_cnt=1; req_rdy=0 while beat 1 is presented.
- Page wrap with override: ea=0xFF8, size=100, dir_ig_57_b=0 →
  - beat 1: idx=0x3F, offs=56, len=8;
  - beat 2: idx=0x01 (0 with bit 5 forced), len=8, pg_wrap=1.
- Backpressure: split request with arr_rdy=0 for 3 cycles → beat 1 held unchanged for 3 cycles; then beat 2; total 5 cycles from acceptance to final retire.
- Back-to-back and error: two unsplit requests, the second offered on the edge beat 1 retires → accepted that edge, presented next cycle. size=111 → len=1 and a single-cycle size_err pulse.
- Reset/saturation: assert rst while beat 2 is pending → arr_val=0 next cycle, split_cnt=0. Then 260 split requests → split_cnt=255.

Source files
------------

// File: rtl/lq_agen_split_seq.sv
// rtl/lq_agen_split_seq.sv - load/store array-access sequencer with cache-line split
//
// Takes the 12-bit low effective address (EA 52:63) from the agen adder.
// Each accepted request becomes one array beat, or two beats when the access
// crosses a 64-byte line. Beats are registered and held stable under arr_rdy=0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_val/req_rdy     request handshake (req_rdy is combinational from arr_rdy)
//   req_ea[0:11]        EA 52:63, [0] is MSB; [0:5] line index, [6:11] byte offset
//   req_size[0:2]       log2 of access bytes (1..16 B); 101-111 illegal -> 1 B
//   req_dir_ig_57_b     active-low, forces index LSB (EA 57) to 1 on every beat
//   req_tag[0:3]        opaque tag echoed on each beat
//   arr_val/arr_rdy     beat handshake toward the L1 directory/data index port
//   arr_idx, arr_offs   line index and byte offset of the beat
//   arr_len             bytes in the beat (1..16)
//   arr_tag             captured request tag
//   arr_first/arr_last  beat position within the request
//   arr_pg_wrap         second beat whose index wrapped 63 -> 0
//   size_err            one-cycle pulse after accepting an illegal size
//   split_cnt           saturating count of split requests

module lq_agen_split_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [0:11] req_ea,
    input  logic [0:2]  req_size,
    input  logic        req_dir_ig_57_b,
    input  logic [0:3]  req_tag,
    output logic        arr_val,
    input  logic        arr_rdy,
    output logic [0:5]  arr_idx,
    output logic [0:5]  arr_offs,
    output logic [0:4]  arr_len,
    output logic [0:3]  arr_tag,
    output logic        arr_first,
    output logic        arr_last,
    output logic        arr_pg_wrap,
    output logic        size_err,
    output logic [0:7]  split_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t     state;

    // Second-beat fields, computed at acceptance so beat 2 needs no request inputs.
    logic [5:0] b2_idx;
    logic [4:0] b2_len;
    logic       b2_pg_wrap;

    logic [5:0] ea_idx;
    logic [5:0] ea_offs;
    logic [4:0] len_l;
    logic       size_bad;
    logic [6:0] end_e;
    logic       split;
    logic [5:0] force_57;
    logic [5:0] idx1;
    logic [5:0] idx2_raw;
    logic [5:0] idx2;
    logic [3:0] neg_offs_lo;
    logic [4:0] len1;
    logic [4:0] len2;
    logic       accept;
    logic       retire;

    assign ea_idx  = req_ea[0:5];
    assign ea_offs = req_ea[6:11];

    always_comb begin
        len_l    = 5'd1;
        size_bad = 1'b0;
        case (req_size)
            3'b000:  len_l = 5'd1;
            3'b001:  len_l = 5'd2;
            3'b010:  len_l = 5'd4;
            3'b011:  len_l = 5'd8;
            3'b100:  len_l = 5'd16;
            default: size_bad = 1'b1;
        endcase
    end

    // End offset in 7 bits; the access spills into the next line when it passes 64.
    assign end_e = {1'b0, ea_offs} + {2'b00, len_l};
    assign split = (end_e > 7'd64);

    // Index bit 5 is EA 57, the LSB of the index field.
    assign force_57 = {5'b00000, ~req_dir_ig_57_b};
    assign idx1     = ea_idx | force_57;
    // Increment the raw index first, then apply the override.
    assign idx2_raw = ea_idx + 6'd1;
    assign idx2     = idx2_raw | force_57;

    // A split implies offset 49..63, so 64-o is 1..15 and equals 16 minus the
    // low offset nibble; likewise e-64 is 1..15 and is just the low nibble of e.
    assign neg_offs_lo = 4'd0 - ea_offs[3:0];
    assign len1        = split ? {1'b0, neg_offs_lo} : len_l;
    assign len2        = {1'b0, end_e[3:0]};

    assign req_rdy = ~arr_val | (arr_rdy & arr_last);
    assign accept  = req_val & req_rdy;
    assign retire  = arr_val & arr_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            arr_val     <= 1'b0;
            arr_idx     <= 6'd0;
            arr_offs    <= 6'd0;
            arr_len     <= 5'd0;
            arr_tag     <= 4'd0;
            arr_first   <= 1'b0;
            arr_last    <= 1'b0;
            arr_pg_wrap <= 1'b0;
            size_err    <= 1'b0;
            split_cnt   <= 8'd0;
            b2_idx      <= 6'd0;
            b2_len      <= 5'd0;
            b2_pg_wrap  <= 1'b0;
        end else begin
            size_err <= accept & size_bad;

            // An accept can only coincide with the retire of a last beat, so it
            // takes priority over the retire-only transitions below.
            if (accept) begin
                state       <= ST_ONE;
                arr_val     <= 1'b1;
                arr_idx     <= idx1;
                arr_offs    <= ea_offs;
                arr_len     <= len1;
                arr_tag     <= req_tag;
                arr_first   <= 1'b1;
                arr_last    <= ~split;
                arr_pg_wrap <= 1'b0;
                b2_idx      <= idx2;
                b2_len      <= len2;
                b2_pg_wrap  <= (ea_idx == 6'd63);
                if (split && (split_cnt != 8'hFF)) begin
                    split_cnt <= split_cnt + 8'd1;
                end
            end else if (retire) begin
                if ((state == ST_ONE) && !arr_last) begin
                    state       <= ST_TWO;
                    arr_idx     <= b2_idx;
                    arr_offs    <= 6'd0;
                    arr_len     <= b2_len;
                    arr_first   <= 1'b0;
                    arr_last    <= 1'b1;
                    arr_pg_wrap <= b2_pg_wrap;
                end else begin
                    state   <= ST_IDLE;
                    arr_val <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lq_agen_split_seq.sv
// tb/tb_lq_agen_split_seq.sv - self-checking bench for lq_agen_split_seq

module tb_lq_agen_split_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic [0:11] req_ea;
    logic [0:2]  req_size;
    logic        req_dir_ig_57_b;
    logic [0:3]  req_tag;
    logic        arr_val;
    logic        arr_rdy;
    logic [0:5]  arr_idx;
    logic [0:5]  arr_offs;
    logic [0:4]  arr_len;
    logic [0:3]  arr_tag;
    logic        arr_first;
    logic        arr_last;
    logic        arr_pg_wrap;
    logic        size_err;
    logic [0:7]  split_cnt;

    lq_agen_split_seq dut (
        .clk             (clk),
        .rst             (rst),
        .req_val         (req_val),
        .req_rdy         (req_rdy),
        .req_ea          (req_ea),
        .req_size        (req_size),
        .req_dir_ig_57_b (req_dir_ig_57_b),
        .req_tag         (req_tag),
        .arr_val         (arr_val),
        .arr_rdy         (arr_rdy),
        .arr_idx         (arr_idx),
        .arr_offs        (arr_offs),
        .arr_len         (arr_len),
        .arr_tag         (arr_tag),
        .arr_first       (arr_first),
        .arr_last        (arr_last),
        .arr_pg_wrap     (arr_pg_wrap),
        .size_err        (size_err),
        .split_cnt       (split_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int offs;
        int len;
        int tag;
        bit first;
        bit last;
        bit wrap;
    } beat_t;

    beat_t q[$];
    int    cnt_exp  = 0;
    bit    serr_exp = 1'b0;
    bit    last_acc = 1'b0;
    bit    chk_en   = 1'b0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: expand one request into the list of beats it must produce.
    function automatic void push_req(input int ea, input int sz, input bit ig, input int tag);
        int    len  = (sz <= 4) ? (1 << sz) : 1;
        int    line = ea / 64;
        int    off  = ea % 64;
        beat_t b;
        b.tag   = tag;
        b.first = 1'b1;
        b.wrap  = 1'b0;
        b.idx   = ig ? line : (line | 1);
        b.offs  = off;
        if (off + len <= 64) begin
            b.len  = len;
            b.last = 1'b1;
            q.push_back(b);
        end else begin
            b.len  = 64 - off;
            b.last = 1'b0;
            q.push_back(b);
            b.first = 1'b0;
            b.last  = 1'b1;
            b.idx   = ig ? ((line + 1) % 64) : (((line + 1) % 64) | 1);
            b.offs  = 0;
            b.len   = off + len - 64;
            b.wrap  = (line == 63);
            q.push_back(b);
            if (cnt_exp < 255) cnt_exp++;
        end
    endfunction

    // One clock: compare outputs at the falling edge, then advance the model.
    task automatic do_cycle();
        bit m_rdy;
        bit m_acc;
        bit m_ret;
        @(negedge clk);
        m_rdy = (q.size() == 0) || (arr_rdy && q.size() == 1);
        if (chk_en) begin
            chk("req_rdy", req_rdy, m_rdy);
            chk("arr_val", arr_val, q.size() != 0);
            if (q.size() != 0) begin
                chk("arr_idx", arr_idx, q[0].idx);
                chk("arr_offs", arr_offs, q[0].offs);
                chk("arr_len", arr_len, q[0].len);
                chk("arr_tag", arr_tag, q[0].tag);
                chk("arr_first", arr_first, q[0].first);
                chk("arr_last", arr_last, q[0].last);
                chk("arr_pg_wrap", arr_pg_wrap, q[0].wrap);
            end
            chk("split_cnt", split_cnt, cnt_exp);
            chk("size_err", size_err, serr_exp);
        end
        m_acc = req_val && m_rdy;
        m_ret = (q.size() != 0) && arr_rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_exp  = 0;
            serr_exp = 1'b0;
            last_acc = 1'b0;
            chk_en   = 1'b1;
        end else begin
            if (m_ret) void'(q.pop_front());
            serr_exp = m_acc && (req_size > 3'd4);
            if (m_acc) push_req(int'(req_ea), int'(req_size), req_dir_ig_57_b, int'(req_tag));
            last_acc = m_acc;
        end
        #1;
    endtask

    task automatic offer(input int ea, input int sz, input bit ig, input int tag);
        req_ea          = 12'(ea);
        req_size        = 3'(sz);
        req_dir_ig_57_b = ig;
        req_tag         = 4'(tag);
        req_val         = 1'b1;
        last_acc        = 1'b0;
        for (int i = 0; i < 50 && !last_acc; i++) do_cycle();
        req_val = 1'b0;
        if (!last_acc) chk("offer_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int n;
        rst             = 1'b1;
        req_val         = 1'b0;
        req_ea          = '0;
        req_size        = '0;
        req_dir_ig_57_b = 1'b1;
        req_tag         = '0;
        arr_rdy         = 1'b0;
        do_cycle();
        do_cycle();
        rst = 1'b0;

        chk("rst_val", arr_val, 0);
        chk("rst_idx", arr_idx, 0);
        chk("rst_offs", arr_offs, 0);
        chk("rst_len", arr_len, 0);
        chk("rst_tag", arr_tag, 0);
        chk("rst_flags", {arr_first, arr_last, arr_pg_wrap, size_err}, 0);
        chk("rst_cnt", split_cnt, 0);
        chk("rst_rdy", req_rdy, 1);

        // Unsplit access
        arr_rdy = 1'b1;
        offer(12'h123, 2, 1'b1, 5);
        chk("u_val", arr_val, 1);
        chk("u_idx", arr_idx, 6'h04);
        chk("u_offs", arr_offs, 6'h23);
        chk("u_len", arr_len, 4);
        chk("u_fl", {arr_first, arr_last}, 2'b11);
        chk("u_cnt", split_cnt, 0);
        do_cycle();

        // Line split
        offer(12'h03C, 3, 1'b1, 6);
        chk("s1_idx", arr_idx, 0);
        chk("s1_offs", arr_offs, 60);
        chk("s1_len", arr_len, 4);
        chk("s1_fl", {arr_first, arr_last}, 2'b10);
        chk("s1_rdy", req_rdy, 0);
        do_cycle();
        chk("s2_idx", arr_idx, 1);
        chk("s2_offs", arr_offs, 0);
        chk("s2_len", arr_len, 4);
        chk("s2_lw", {arr_last, arr_pg_wrap}, 2'b10);
        chk("s2_cnt", split_cnt, 1);
        do_cycle();

        // Page wrap with index override
        offer(12'hFF8, 4, 1'b0, 7);
        chk("w1_idx", arr_idx, 6'h3F);
        chk("w1_offs", arr_offs, 56);
        chk("w1_len", arr_len, 8);
        do_cycle();
        chk("w2_idx", arr_idx, 6'h01);
        chk("w2_len", arr_len, 8);
        chk("w2_wrap", arr_pg_wrap, 1);
        do_cycle();

        // Backpressure on a split request
        arr_rdy = 1'b0;
        offer(12'h03C, 3, 1'b1, 8);
        n = 0;
        repeat (3) begin
            do_cycle();
            n++;
        end
        chk("bp_hold_idx", arr_idx, 0);
        chk("bp_hold_first", arr_first, 1);
        arr_rdy = 1'b1;
        while (arr_val && n < 20) begin
            do_cycle();
            n++;
        end
        chk("bp_cycles", n, 5);

        // Back-to-back unsplit, then an illegal size
        offer(12'h100, 0, 1'b1, 3);
        offer(12'h200, 1, 1'b1, 4);
        chk("b2b_tag", arr_tag, 4);
        chk("b2b_idx", arr_idx, 8);
        do_cycle();
        offer(12'h005, 7, 1'b1, 9);
        chk("err_len", arr_len, 1);
        chk("err_pulse", size_err, 1);
        do_cycle();
        chk("err_clear", size_err, 0);
        do_cycle();

        // Reset while beat 2 is pending
        offer(12'h03C, 3, 1'b1, 2);
        do_cycle();
        chk("rm_pending", {arr_val, arr_last}, 2'b11);
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        chk("rm_val", arr_val, 0);
        chk("rm_cnt", split_cnt, 0);

        // Saturation of split_cnt
        for (int i = 0; i < 260; i++) offer(12'h03C, 3, 1'b1, i);
        do_cycle();
        do_cycle();
        chk("sat_cnt", split_cnt, 255);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            req_val         = ($urandom_range(0, 9) < 6);
            req_ea          = 12'($urandom);
            if ($urandom_range(0, 1) == 1) req_ea[6:7] = 2'b11;
            req_size        = 3'($urandom_range(0, 7));
            req_dir_ig_57_b = 1'($urandom);
            req_tag         = 4'($urandom);
            arr_rdy         = ($urandom_range(0, 9) < 7);
            do_cycle();
        end
        rst     = 1'b0;
        req_val = 1'b0;
        arr_rdy = 1'b1;
        repeat (4) do_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
